// File: rtl/igmii_rx_framer_if.sv
// igmii_rx_framer_if: GMII-style receive byte lane in, framed payload stream out.
interface igmii_rx_framer_if #(parameter int DW = 8);
    logic          i_clk_en;
    logic          i_dv;
    logic [DW-1:0] i_d;
    logic          i_er;
    logic          o_vld;
    logic [DW-1:0] o_data;
    logic          o_sop;
    logic          o_eop;
    logic          o_err;
    logic [15:0]   o_len;
    modport master (input i_clk_en, i_dv, i_d, i_er, output o_vld, o_data, o_sop, o_eop, o_err, o_len);
    modport slave (output i_clk_en, i_dv, i_d, i_er, input o_vld, o_data, o_sop, o_eop, o_err, o_len);
endinterface

// File: rtl/igmii_rx_framer.sv
// igmii_rx_framer: strips preamble/SFD from a GMII byte stream, emits payload with sop/eop/err/len and keeps frame statistics.
module igmii_rx_framer #(
    parameter int DW      = 8,
    parameter int PRE_MIN = 7,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    igmii_rx_framer_if.master    rx,
    input  logic                 i_cnt_clr,
    output logic [CNT_W-1:0]     o_frm_cnt,
    output logic [CNT_W-1:0]     o_err_cnt
);
    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
    localparam logic [DW-1:0] B_PRE = DW'(8'h55);
    localparam logic [DW-1:0] B_SFD = DW'(8'hD5);
    localparam logic [2:0]    PRE_L = 3'(PRE_MIN);
    localparam logic [15:0]   MIN_L = 16'(MIN_LEN);
    localparam logic [15:0]   MAX_L = 16'(MAX_LEN);
    state_t        state, state_n;
    logic [2:0]    pre, pre_n;
    logic [DW-1:0] hold, hold_n;
    logic [15:0]   len, len_n, len_inc;
    logic          have, have_n, first, first_n, eacc, eacc_n;
    logic          vld_n, sop_n, eop_n, err_n, frm_inc, err_inc, bad;
    assign len_inc = &len ? len : len + 16'd1;
    assign bad = eacc | rx.i_er | (len < MIN_L) | (len > MAX_L);
    // Each payload byte is held one slot so the last one can be tagged eop when i_dv drops.
    always_comb begin
        state_n = state;
        pre_n   = pre;
        hold_n  = hold;
        have_n  = have;
        first_n = first;
        eacc_n  = eacc;
        len_n   = len;
        vld_n   = 1'b0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        err_n   = 1'b0;
        frm_inc = 1'b0;
        err_inc = 1'b0;
        if (rx.i_clk_en)
            case (state)
                IDLE: if (rx.i_dv) begin
                    state_n = rx.i_d == B_PRE ? PRE : DROP;
                    pre_n   = 3'd1;
                end
                PRE: if (!rx.i_dv) state_n = IDLE;
                else if (!rx.i_er && rx.i_d == B_PRE) pre_n = &pre ? pre : pre + 3'd1;
                else if (!rx.i_er && rx.i_d == B_SFD && pre >= PRE_L) begin
                    state_n = DATA;
                    have_n  = 1'b0;
                    first_n = 1'b1;
                    eacc_n  = 1'b0;
                    len_n   = 16'd0;
                end
                else state_n = DROP;
                DATA: begin
                    vld_n   = have;
                    sop_n   = have & first;
                    first_n = have ? 1'b0 : first;
                    if (rx.i_dv) begin
                        hold_n = rx.i_d;
                        have_n = 1'b1;
                        len_n  = len_inc;
                        eacc_n = eacc | rx.i_er;
                    end else begin
                        state_n = IDLE;
                        eop_n   = have;
                        err_n   = have & bad;
                        frm_inc = have & ~bad;
                        err_inc = ~have | bad;
                    end
                end
                default: if (!rx.i_dv) state_n = IDLE;
            endcase
    end
    always_ff @(posedge i_clk)
        if (i_rst) begin
            state     <= DROP;
            pre       <= '0;
            hold      <= '0;
            have      <= 1'b0;
            first     <= 1'b0;
            eacc      <= 1'b0;
            len       <= '0;
            rx.o_vld  <= 1'b0;
            rx.o_sop  <= 1'b0;
            rx.o_eop  <= 1'b0;
            rx.o_err  <= 1'b0;
            rx.o_data <= '0;
            rx.o_len  <= '0;
            o_frm_cnt <= '0;
            o_err_cnt <= '0;
        end else begin
            state     <= state_n;
            pre       <= pre_n;
            hold      <= hold_n;
            have      <= have_n;
            first     <= first_n;
            eacc      <= eacc_n;
            len       <= len_n;
            rx.o_vld  <= vld_n;
            rx.o_sop  <= sop_n;
            rx.o_eop  <= eop_n;
            rx.o_err  <= err_n;
            rx.o_data <= vld_n ? hold : rx.o_data;
            rx.o_len  <= eop_n ? len : rx.o_len;
            o_frm_cnt <= i_cnt_clr ? '0 : o_frm_cnt + CNT_W'(frm_inc & ~&o_frm_cnt);
            o_err_cnt <= i_cnt_clr ? '0 : o_err_cnt + CNT_W'(err_inc & ~&o_err_cnt);
        end
endmodule

// File: tb/tb_igmii_rx_framer.sv
// tb_igmii_rx_framer: directed plus randomized frames checked against a frame-level reference model.
module tb_igmii_rx_framer;
    localparam int CW      = 4;
    localparam int CMAX    = 2**CW - 1;
    localparam int PRE_MIN = 7;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    typedef struct packed {
        logic [7:0]  d;
        logic        sop;
        logic        eop;
        logic        err;
        logic [15:0] len;
    } exp_t;
    logic clk, rst, cnt_clr, run, prev_vld;
    logic [CW-1:0] frm_cnt, err_cnt;
    int checks, errors, gap_n, exp_frm, exp_err;
    logic [7:0] fb[$];
    logic fe[$];
    exp_t exq[$];
    exp_t e;
    igmii_rx_framer_if #(.DW(8)) rx();
    igmii_rx_framer #(.DW(8), .PRE_MIN(PRE_MIN), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .rx(rx), .i_cnt_clr(cnt_clr), .o_frm_cnt(frm_cnt), .o_err_cnt(err_cnt));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    // Frame-level reference: decide acceptance from the byte list, then queue the expected payload stream.
    task automatic model(input logic er_end);
        int n, plen;
        logic bad;
        exp_t x;
        n = 0;
        while (n < fb.size() && fb[n] == 8'h55) n++;
        if (n < PRE_MIN || n >= fb.size() || fb[n] != 8'hD5 || fe[n]) return;
        plen = fb.size() - n - 1;
        if (plen == 0) begin
            if (exp_err < CMAX) exp_err++;
            return;
        end
        bad = er_end || plen < MIN_LEN || plen > MAX_LEN;
        for (int i = n + 1; i < fb.size(); i++) bad |= fe[i];
        for (int i = 0; i < plen; i++) begin
            x.d = fb[n + 1 + i];
            x.sop = (i == 0);
            x.eop = (i == plen - 1);
            x.err = x.eop && bad;
            x.len = 16'(plen);
            exq.push_back(x);
        end
        if (bad) begin if (exp_err < CMAX) exp_err++; end
        else if (exp_frm < CMAX) exp_frm++;
    endtask
    task automatic build(input int npre, input int plen, input int erpos, input logic rnd);
        fb.delete();
        fe.delete();
        repeat (npre) begin fb.push_back(8'h55); fe.push_back(1'b0); end
        fb.push_back(8'hD5);
        fe.push_back(1'b0);
        for (int i = 0; i < plen; i++) begin
            fb.push_back(rnd ? 8'($urandom) : 8'(i));
            fe.push_back(i == erpos);
        end
    endtask
    task automatic slot(input logic dv, input logic [7:0] d, input logic er, input logic clr);
        rx.i_clk_en = 1'b1;
        rx.i_dv = dv;
        rx.i_d = d;
        rx.i_er = er;
        cnt_clr = clr;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        for (int k = 1; k < gap_n; k++) begin
            rx.i_clk_en = 1'b0;
            rx.i_dv = 1'($urandom);
            rx.i_d = 8'($urandom);
            rx.i_er = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask
    task automatic send(input int gap, input logic er_end, input logic clr_end);
        gap_n = gap;
        model(er_end);
        if (clr_end) begin exp_frm = 0; exp_err = 0; end
        foreach (fb[i]) slot(1'b1, fb[i], fe[i], 1'b0);
        slot(1'b0, 8'($urandom), er_end, clr_end);
        repeat (2) slot(1'b0, 8'h00, 1'b0, 1'b0);
        chk("frm_cnt", frm_cnt, exp_frm);
        chk("err_cnt", err_cnt, exp_err);
        chk("drained", exq.size(), 0);
    endtask
    always @(negedge clk) if (run) begin
        if (rx.o_vld) begin
            chk("vld_expected", exq.size() != 0, 1);
            if (exq.size() != 0) begin
                e = exq.pop_front();
                chk("data", rx.o_data, e.d);
                chk("sop", rx.o_sop, e.sop);
                chk("eop", rx.o_eop, e.eop);
                chk("err", rx.o_err, e.err);
                if (e.eop) chk("len", rx.o_len, e.len);
            end
            if (gap_n > 1) chk("vld_width", prev_vld, 0);
        end else chk("idle_flags", {rx.o_sop, rx.o_eop, rx.o_err}, 0);
        prev_vld = rx.o_vld;
    end
    initial begin
        int plens[7];
        checks = 0; errors = 0; exp_frm = 0; exp_err = 0; gap_n = 1; run = 1'b0; prev_vld = 1'b0;
        rst = 1'b1; cnt_clr = 1'b0;
        rx.i_clk_en = 1'b0; rx.i_dv = 1'b0; rx.i_d = 8'h00; rx.i_er = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", rx.o_vld, 0);
        chk("rst_data", rx.o_data, 0);
        chk("rst_len", rx.o_len, 0);
        chk("rst_frm_cnt", frm_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        run = 1'b1;
        repeat (2) slot(1'b0, 8'h00, 1'b0, 1'b0);
        // Reference 64-byte frame, every cycle and then every 4th cycle.
        build(7, 64, -1, 1'b0); send(1, 1'b0, 1'b0);
        build(7, 64, -1, 1'b0); send(4, 1'b0, 1'b0);
        // Payload error, bad preamble, undersize and oversize.
        build(7, 100, 10, 1'b1); send(1, 1'b0, 1'b0);
        build(2, 10, -1, 1'b0); fb[2] = 8'h54; send(1, 1'b0, 1'b0);
        build(7, 20, -1, 1'b1); send(2, 1'b0, 1'b0);
        build(7, 1600, -1, 1'b1); send(1, 1'b0, 1'b0);
        // Randomized frames: short preambles, 1-byte and boundary lengths, stray errors.
        plens = '{0, 1, 2, 63, 64, 65, 0};
        for (int f = 0; f < 10; f++) begin
            int np, pl;
            np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(7, 8);
            plens[6] = $urandom_range(3, 150);
            pl = plens[$urandom_range(0, 6)];
            build(np, pl, ($urandom_range(0, 5) == 0) ? $urandom_range(0, pl) : -1, 1'b1);
            send($urandom_range(1, 3), $urandom_range(0, 7) == 0, 1'b0);
        end
        // Reset while payload byte 30 is on the wire.
        gap_n = 1;
        build(7, 40, -1, 1'b0);
        for (int i = 0; i < 29; i++) begin
            e.d = 8'(i); e.sop = (i == 0); e.eop = 1'b0; e.err = 1'b0; e.len = 16'd0;
            exq.push_back(e);
        end
        for (int i = 0; i < 38; i++) slot(1'b1, fb[i], 1'b0, 1'b0);
        rx.i_clk_en = 1'b1; rx.i_dv = 1'b1; rx.i_d = fb[38]; rx.i_er = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; exp_frm = 0; exp_err = 0;
        chk("mid_rst_frm_cnt", frm_cnt, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_vld", rx.o_vld, 0);
        for (int i = 39; i < 44; i++) slot(1'b1, fb[i], 1'b0, 1'b0);
        repeat (2) slot(1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid_rst_drained", exq.size(), 0);
        build(7, 64, -1, 1'b1); send(1, 1'b0, 1'b0);
        // Counter clear, error counter saturation, clear colliding with an increment.
        slot(1'b0, 8'h00, 1'b0, 1'b1);
        exp_frm = 0; exp_err = 0;
        chk("clr_frm_cnt", frm_cnt, 0);
        chk("clr_err_cnt", err_cnt, 0);
        for (int f = 0; f < CMAX + 2; f++) begin build(7, 0, -1, 1'b0); send(1, 1'b0, 1'b0); end
        chk("err_cnt_sat", err_cnt, CMAX);
        build(7, 64, -1, 1'b1); send(1, 1'b0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/igmii_rx_framer.md
IGMII_RX_FRAMER -- requirements
Module: igmii_rx_framer

Interface
REQ-001 Parameter DW, default 8: byte width of i_d and o_data; only value 8 is supported in this revision.
REQ-002 Parameter PRE_MIN, default 7: minimum number of 0x55 preamble bytes before SFD; legal range 1..7.
REQ-003 Parameter MIN_LEN, default 64: minimum legal frame length in bytes after SFD.
REQ-004 Parameter MAX_LEN, default 1518: maximum legal frame length in bytes after SFD.
REQ-005 Parameter CNT_W, default 32: width of the statistics counters.
REQ-006 i_clk  in  1  single clock; all logic on rising edge.
REQ-007 i_rst  in  1  synchronous, active-high reset.
REQ-008 i_clk_en  in  1  byte strobe; i_dv, i_d and i_er are sampled only when high.
REQ-009 i_dv  in  1  receive data valid.
REQ-010 i_d  in  DW  receive byte.
REQ-011 i_er  in  1  receive error.
REQ-012 i_cnt_clr  in  1  synchronous clear of both statistics counters.
REQ-013 o_vld  out  1  output byte valid; one i_clk pulse per byte.
REQ-014 o_data  out  DW  payload byte; preamble and SFD are stripped.
REQ-015 o_sop  out  1  first payload byte, qualified by o_vld.
REQ-016 o_eop  out  1  last payload byte, qualified by o_vld.
REQ-017 o_err  out  1  frame bad, valid with o_eop.
REQ-018 o_len  out  16  payload length, valid with o_eop.
REQ-019 o_frm_cnt  out  CNT_W  count of good frames.
REQ-020 o_err_cnt  out  CNT_W  count of bad frames.

Function
REQ-021 State machine states: IDLE, PRE, DATA, DROP; transitions are evaluated only on cycles with i_clk_en=1.
REQ-022 IDLE: i_dv=1 with i_d=0x55 -> PRE with preamble count 1; i_dv=1 with any other i_d -> DROP; i_dv=0 -> stay in IDLE.
REQ-023 PRE, byte 0x55: preamble count increments, saturating at 7.
REQ-024 PRE, byte 0xD5 with count >= PRE_MIN: -> DATA.
REQ-025 PRE, any other byte, a short preamble, or i_er=1: -> DROP; no output and no counter change.
REQ-026 PRE or DROP, i_dv=0 -> IDLE.
REQ-027 DATA: each received byte is held one byte slot and emitted when the next byte is sampled, so o_vld pulses one i_clk cycle after the i_clk_en cycle in which the following byte or the i_dv=0 is sampled.
REQ-028 DATA, i_dv=0 sampled: emit the held byte with o_eop=1, then -> IDLE.
REQ-029 A frame whose i_dv falls right after SFD (zero payload bytes) emits no o_vld, is counted in o_err_cnt, and -> IDLE.
REQ-030 o_sop=1 on the first emitted byte; on a 1-byte frame o_sop and o_eop are both 1.
REQ-031 Payload length counter increments per DATA byte and saturates at 0xFFFF; o_len carries its value with o_eop.
REQ-032 o_err=1 if any of: i_er=1 on any DATA byte, or the error is sampled with i_dv=0 at the end of the frame; length < MIN_LEN; length > MAX_LEN.
REQ-033 Oversize frames are still forwarded in full.
REQ-034 i_er with i_dv=0 in IDLE is ignored.
REQ-035 On eop: o_err=0 increments o_frm_cnt, o_err=1 increments o_err_cnt; both counters saturate at all-ones.
REQ-036 i_cnt_clr=1 zeroes both counters next cycle; if it coincides with an increment, the clear wins and the result is 0.
REQ-037 All outputs are registered; o_vld, o_sop, o_eop and o_err are 0 on every cycle without an emitted byte.
REQ-038 o_data and o_len retain their last value when o_vld=0.

Reset
REQ-039 i_rst=1: state -> DROP; held byte discarded; o_vld, o_sop, o_eop, o_err = 0; o_data, o_len, o_frm_cnt, o_err_cnt = 0.
REQ-040 A frame in progress at reset is neither emitted nor counted; reception resumes only after i_dv=0 is sampled.
REQ-041 Reset has priority over i_cnt_clr and all inputs.

Verification
REQ-042 7x0x55, 0xD5, 64 payload bytes 0x00..0x3F, i_clk_en=1 every cycle -> 64 o_vld pulses; sop on 0x00; eop on 0x3F with o_len=64 and o_err=0; o_frm_cnt=1.
REQ-043 Same frame with i_clk_en=1 every 4th cycle -> identical o_data sequence, o_vld one cycle wide, o_frm_cnt=1.
REQ-044 i_er=1 on payload byte 10 of a 100-byte frame -> 100 bytes emitted; eop has o_err=1 and o_len=100; o_err_cnt=1; o_frm_cnt unchanged.
REQ-045 Preamble 0x55,0x55,0x54,... -> no o_vld until the next valid frame; counters unchanged. A 20-byte frame -> o_err=1, o_len=20. A 1600-byte frame -> o_err=1, o_len=1600.
REQ-046 i_rst pulsed at payload byte 30 with i_dv held high -> no further output for that frame; next clean 64-byte frame is received normally; both counters read 0 then o_frm_cnt=1.
REQ-047 o_err_cnt at all-ones plus a bad frame -> stays all-ones; i_cnt_clr on the eop emit cycle -> both counters 0.
